// File: rtl/cpu_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : cpu_multicycle_ctrl                                           |
// | Purpose  : Multicycle control FSM for the ARMv4-subset core. Sequences    |
// |            a shared instruction/data memory through a req/ready          |
// |            handshake, evaluates condition codes against held NZCV flags  |
// |            and traps a stalled memory access into a sticky FAULT state.  |
// | Ports    : clk, rst (sync, active-high)                                  |
// |            Instr[31:0]   current IR contents                             |
// |            ALUFlags[3:0] {N,Z,C,V} from the ALU this cycle               |
// |            MemReady      memory completes the access this cycle          |
// |            MemReq/MemWrite/AdrSrc/IRWrite/PCWrite/RegWrite  strobes      |
// |            ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl muxes |
// |            Fault         sticky timeout / undefined-Op indication        |
// | Options  : `define CPU_MC_PERF_EN adds CycleCount[31:0], RetireCount[31:0]|
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module cpu_multicycle_ctrl #(
  parameter int WAIT_W      = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  RegSrc,
  output logic [3:0]  ALUControl,
  output logic        Fault
`ifdef CPU_MC_PERF_EN
  ,
  output logic [31:0] CycleCount,
  output logic [31:0] RetireCount
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXECR  = 4'd6,  S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9,  S_FAULT  = 4'd10
  } state_t;

  localparam logic [WAIT_W-1:0] c_timeout = WAIT_W'(MEM_TIMEOUT);
  localparam logic [3:0] c_add = 4'b0000, c_sub = 4'b0001, c_and = 4'b0010,
                         c_orr = 4'b0011, c_eor = 4'b0100, c_mov = 4'b0101;

  state_t            r_state, w_next;
  logic [3:0]        r_flags;
  logic [WAIT_W-1:0] r_wait;
  logic              r_fault;

  // Instruction fields
  logic [1:0] w_op;
  logic [3:0] w_cmd, w_rd, w_cond;
  logic       w_i, w_s, w_u, w_l;
  assign w_cond = Instr[31:28];
  assign w_op   = Instr[27:26];
  assign w_i    = Instr[25];
  assign w_cmd  = Instr[24:21];
  assign w_u    = Instr[23];
  assign w_s    = Instr[20];
  assign w_l    = Instr[20];
  assign w_rd   = Instr[15:12];

  // Register numbers and immediates are consumed by the datapath only
  logic w_unused_ok;
  assign w_unused_ok = ^{Instr[19:16], Instr[11:0]};

  logic w_is_cmp, w_pcs, w_addsub;
  assign w_is_cmp = (w_cmd == 4'b1010);
  assign w_pcs    = ((w_rd == 4'hF) && !w_is_cmp) || (w_op == 2'b10);
  assign w_addsub = (w_cmd == 4'b0100) || (w_cmd == 4'b0010) || w_is_cmp;

  logic [3:0] w_dp_alu;
  always_comb begin
    w_dp_alu = c_add;
    case (w_cmd)
      4'b0100:          w_dp_alu = c_add;
      4'b0010, 4'b1010: w_dp_alu = c_sub;
      4'b0000:          w_dp_alu = c_and;
      4'b1100:          w_dp_alu = c_orr;
      4'b0001:          w_dp_alu = c_eor;
      4'b1101:          w_dp_alu = c_mov;
      default:          w_dp_alu = c_add;
    endcase
  end

  // Condition check against the held flags {N,Z,C,V}
  logic w_n, w_z, w_c, w_v, w_condex;
  assign {w_n, w_z, w_c, w_v} = r_flags;
  always_comb begin
    w_condex = 1'b0;
    case (w_cond)
      4'h0: w_condex = w_z;
      4'h1: w_condex = !w_z;
      4'h2: w_condex = w_c;
      4'h3: w_condex = !w_c;
      4'h4: w_condex = w_n;
      4'h5: w_condex = !w_n;
      4'h6: w_condex = w_v;
      4'h7: w_condex = !w_v;
      4'h8: w_condex = w_c && !w_z;
      4'h9: w_condex = !w_c || w_z;
      4'hA: w_condex = (w_n == w_v);
      4'hB: w_condex = (w_n != w_v);
      4'hC: w_condex = !w_z && (w_n == w_v);
      4'hD: w_condex = w_z || (w_n != w_v);
      4'hE: w_condex = 1'b1;
      default: w_condex = 1'b0;
    endcase
  end

  // Memory watchdog: the final permitted wait cycle with no ready traps
  logic w_memreq, w_timeout;
  assign w_memreq  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_timeout = (MEM_TIMEOUT != 0) && w_memreq && !MemReady && (r_wait == c_timeout);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = w_timeout ? S_FAULT : (MemReady ? S_DECODE : S_FETCH);
      S_DECODE: begin
        case (w_op)
          2'b00:   w_next = w_i ? S_EXECI : S_EXECR;
          2'b01:   w_next = S_MEMADR;
          2'b10:   w_next = S_BRANCH;
          default: w_next = S_FAULT;
        endcase
      end
      S_MEMADR: w_next = w_l ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = w_timeout ? S_FAULT : (MemReady ? S_MEMWB : S_MEMRD);
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = w_timeout ? S_FAULT : (MemReady ? S_FETCH : S_MEMWR);
      S_EXECR:  w_next = S_ALUWB;
      S_EXECI:  w_next = S_ALUWB;
      S_ALUWB:  w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_FAULT:  w_next = S_FAULT;
      default:  w_next = S_FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_flags <= 4'b0000;
      r_wait  <= '0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next == S_FAULT)
        r_fault <= 1'b1;
      if (w_next != r_state)
        r_wait <= '0;
      else if (w_memreq && !MemReady && (r_wait != '1))
        r_wait <= r_wait + WAIT_W'(1);
      // N,Z follow every flag-setting op; C,V only arithmetic ones
      if (((r_state == S_EXECR) || (r_state == S_EXECI)) && w_s && w_condex) begin
        r_flags[3:2] <= ALUFlags[3:2];
        if (w_addsub)
          r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

`ifdef CPU_MC_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      CycleCount  <= 32'd0;
      RetireCount <= 32'd0;
    end else begin
      if (r_state != S_FAULT)
        CycleCount <= CycleCount + 32'd1;
      if ((w_next == S_FETCH) && (r_state != S_FETCH))
        RetireCount <= RetireCount + 32'd1;
    end
  end
`endif

  always_comb begin
    MemReq     = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 2'b00;
    RegSrc     = 3'b000;
    ALUControl = c_add;
    Fault      = r_fault;
    // Register/immediate selects follow the IR once it holds the new
    // instruction; during FETCH the IR is stale so they stay at 0.
    // RegSrc[2] is reserved and always 0.
    if ((r_state != S_FETCH) && (r_state != S_FAULT)) begin
      ImmSrc = (w_op == 2'b11) ? 2'b00 : w_op;
      RegSrc = {1'b0, (w_op == 2'b01) && !w_l, (w_op == 2'b10)};
    end
    case (r_state)
      S_FETCH: begin
        MemReq    = 1'b1;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB    = 2'b01;
        ALUControl = w_u ? c_add : c_sub;
      end
      S_MEMRD: begin
        MemReq = 1'b1;
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = w_condex;
      end
      S_MEMWR: begin
        MemReq   = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = w_condex;
      end
      S_EXECR: ALUControl = w_dp_alu;
      S_EXECI: begin
        ALUSrcB    = 2'b01;
        ALUControl = w_dp_alu;
      end
      S_ALUWB: begin
        RegWrite = w_condex && !w_is_cmp;
        PCWrite  = w_condex && w_pcs;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = w_condex;
      end
      default: ;
    endcase
    if (rst) begin
      MemReq     = 1'b0;
      MemWrite   = 1'b0;
      AdrSrc     = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ImmSrc     = 2'b00;
      RegSrc     = 3'b000;
      ALUControl = 4'b0000;
      Fault      = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_multicycle_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_cpu_multicycle_ctrl                                        |
// | Purpose  : Directed instruction sequences for cpu_multicycle_ctrl with a |
// |            queue of hand-derived per-cycle control vectors checked by an |
// |            independent monitor on the falling clock edge.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_cpu_multicycle_ctrl;

  typedef logic [20:0] vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Instr = 32'd0;
  logic [3:0]  ALUFlags = 4'd0;
  logic        MemReady = 1'b0;
  logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, Fault;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc;
  logic [2:0]  RegSrc;
  logic [3:0]  ALUControl;
`ifdef CPU_MC_PERF_EN
  logic [31:0] CycleCount, RetireCount;
`endif

  cpu_multicycle_ctrl #(.WAIT_W(4), .MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .MemReq(MemReq), .MemWrite(MemWrite), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
    .Fault(Fault)
`ifdef CPU_MC_PERF_EN
    , .CycleCount(CycleCount), .RetireCount(RetireCount)
`endif
  );

  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_err = 0;
  vec_t  exp_q[$];
  string tag_q[$];

  vec_t w_obs;
  assign w_obs = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA,
                  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl, Fault};

  function automatic vec_t mk(input logic req, mw, adr, irw, pcw, rw, asa,
                              input logic [1:0] asb, res, imm,
                              input logic [2:0] rs, input logic [3:0] alu,
                              input logic flt);
    return {req, mw, adr, irw, pcw, rw, asa, asb, res, imm, rs, alu, flt};
  endfunction

  // Monitor: one expected vector per cycle, compared mid-cycle
  initial begin : monitor
    vec_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_cmp++;
        if (w_obs !== e) begin
          n_err++;
          $display("FAIL %s: got %06h expected %06h", t, w_obs, e);
        end
      end
    end
  end

  // Hand-derived control vectors
  vec_t v_zero, v_flt, v_frdy, v_fwt, v_ddp, v_xiadd, v_wbw, v_wbn, v_wbpc;
  vec_t v_db, v_br, v_dld, v_mal, v_mrd, v_mwb, v_dst, v_mas, v_msb, v_mwr, v_mwrn;

  task automatic step(input logic r, input logic [31:0] ins, input logic rdy,
                      input vec_t e, input string t);
    rst = r;
    Instr = ins;
    MemReady = rdy;
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int waits);
    for (int k = 0; k < waits; k++) step(1'b0, Instr, 1'b0, v_fwt, "fetch_wait");
    step(1'b0, Instr, 1'b1, v_frdy, "fetch");
  endtask

  task automatic dp_imm(input logic [31:0] ins, input logic wr, input string t);
    fetch(0);
    step(1'b0, ins, 1'b1, v_ddp, "dp_decode");
    step(1'b0, ins, 1'b1, v_xiadd, "dp_execi");
    step(1'b0, ins, 1'b1, wr ? v_wbw : v_wbn, t);
  endtask

  task automatic dp_reg(input logic [31:0] ins, input logic [3:0] alu, input vec_t wb,
                        input string t);
    fetch(0);
    step(1'b0, ins, 1'b1, v_ddp, "dpr_decode");
    step(1'b0, ins, 1'b1, mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,alu,0), "dpr_execr");
    step(1'b0, ins, 1'b1, wb, t);
  endtask

  initial begin
    v_zero = '0;
    v_flt  = mk(0,0,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,4'h0,1);
    v_frdy = mk(1,0,0,1,1,0,1,2'b10,2'b10,2'b00,3'b000,4'h0,0);
    v_fwt  = mk(1,0,0,0,0,0,1,2'b10,2'b10,2'b00,3'b000,4'h0,0);
    v_ddp  = mk(0,0,0,0,0,0,1,2'b10,2'b10,2'b00,3'b000,4'h0,0);
    v_xiadd= mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b00,3'b000,4'h0,0);
    v_wbw  = mk(0,0,0,0,0,1,0,2'b00,2'b00,2'b00,3'b000,4'h0,0);
    v_wbn  = '0;
    v_wbpc = mk(0,0,0,0,1,1,0,2'b00,2'b00,2'b00,3'b000,4'h0,0);
    v_db   = mk(0,0,0,0,0,0,1,2'b10,2'b10,2'b10,3'b001,4'h0,0);
    v_br   = mk(0,0,0,0,1,0,0,2'b01,2'b10,2'b10,3'b001,4'h0,0);
    v_dld  = mk(0,0,0,0,0,0,1,2'b10,2'b10,2'b01,3'b000,4'h0,0);
    v_mal  = mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b01,3'b000,4'h0,0);
    v_mrd  = mk(1,0,1,0,0,0,0,2'b00,2'b00,2'b01,3'b000,4'h0,0);
    v_mwb  = mk(0,0,0,0,0,1,0,2'b00,2'b01,2'b01,3'b000,4'h0,0);
    v_dst  = mk(0,0,0,0,0,0,1,2'b10,2'b10,2'b01,3'b010,4'h0,0);
    v_mas  = mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b01,3'b010,4'h0,0);
    v_msb  = mk(0,0,0,0,0,0,0,2'b01,2'b00,2'b01,3'b010,4'h1,0);
    v_mwr  = mk(1,1,1,0,0,0,0,2'b00,2'b00,2'b01,3'b010,4'h0,0);
    v_mwrn = mk(1,0,1,0,0,0,0,2'b00,2'b00,2'b01,3'b010,4'h0,0);

    @(posedge clk);
    #1;
    // Reset: every output held low
    step(1'b1, 32'h0, 1'b1, v_zero, "reset0");
    step(1'b1, 32'h0, 1'b1, v_zero, "reset1");

    // Three ADDs (one cond-failed) and a branch
    ALUFlags = 4'b0000;
    dp_imm(32'hE2821005, 1'b1, "add_wb");
    ALUFlags = 4'b1111;                       // S=0: must not reach the flags
    dp_imm(32'hE2821005, 1'b1, "add2_wb");
    dp_imm(32'h02833001, 1'b0, "addeq_z0");
    fetch(0);
    step(1'b0, 32'hEA000002, 1'b1, v_db, "b_decode");
    step(1'b0, 32'hEA000002, 1'b1, v_br, "b_branch");
`ifdef CPU_MC_PERF_EN
    n_cmp++;
    if (CycleCount !== 32'd15) begin
      n_err++;
      $display("FAIL cyclecount: got %0d expected 15", CycleCount);
    end
    n_cmp++;
    if (RetireCount !== 32'd4) begin
      n_err++;
      $display("FAIL retirecount: got %0d expected 4", RetireCount);
    end
`endif

    // SUBS sets Z (and C); EQ executes, NE does not
    ALUFlags = 4'b0110;
    dp_reg(32'hE0500000, 4'h1, v_wbw, "subs_wb");
    dp_imm(32'h02833001, 1'b1, "addeq_wb");
    dp_imm(32'h12833001, 1'b0, "addne_wb");

    // ANDS: N,Z from ALU, C,V kept -> flags N=1 Z=0 C=1 V=0
    ALUFlags = 4'b1001;
    dp_reg(32'hE0100000, 4'h2, v_wbw, "ands_wb");
    dp_imm(32'h42833001, 1'b1, "addmi_wb");
    dp_imm(32'h22833001, 1'b1, "addcs_wb");
    dp_imm(32'h62833001, 1'b0, "addvs_wb");
    dp_imm(32'hB2833001, 1'b1, "addlt_wb");
    dp_imm(32'hF2833001, 1'b0, "addnv_wb");

    // CMP: no register write, flags -> Z=1 C=1
    ALUFlags = 4'b0110;
    dp_reg(32'hE1500000, 4'h1, v_wbn, "cmp_wb");
    dp_imm(32'h92833001, 1'b1, "addls_wb");
    dp_imm(32'h82833001, 1'b0, "addhi_wb");

    // MOV PC,R1 writes both register and PC
    dp_reg(32'hE1A0F001, 4'h5, v_wbpc, "movpc_wb");

    // LDR with three wait cycles in MEMRD: 8 cycles total
    fetch(0);
    step(1'b0, 32'hE5921004, 1'b1, v_dld, "ldr_decode");
    step(1'b0, 32'hE5921004, 1'b1, v_mal, "ldr_memadr");
    for (int k = 0; k < 3; k++) step(1'b0, 32'hE5921004, 1'b0, v_mrd, "ldr_memrd_wait");
    step(1'b0, 32'hE5921004, 1'b1, v_mrd, "ldr_memrd");
    step(1'b0, 32'hE5921004, 1'b1, v_mwb, "ldr_memwb");

    // Never-executed STR with negative offset, after a stalled fetch
    fetch(2);
    step(1'b0, 32'hF5021004, 1'b1, v_dst, "strnv_decode");
    step(1'b0, 32'hF5021004, 1'b1, v_msb, "strnv_memadr");
    step(1'b0, 32'hF5021004, 1'b1, v_mwrn, "strnv_memwr");

    // STR zero wait
    fetch(0);
    step(1'b0, 32'hE5821004, 1'b1, v_dst, "str_decode");
    step(1'b0, 32'hE5821004, 1'b1, v_mas, "str_memadr");
    step(1'b0, 32'hE5821004, 1'b1, v_mwr, "str_memwr");

    // Undefined Op -> FAULT until reset
    fetch(0);
    step(1'b0, 32'hEC000000, 1'b1, v_ddp, "undef_decode");
    for (int k = 0; k < 3; k++) step(1'b0, 32'hEC000000, 1'b1, v_flt, "undef_fault");
    step(1'b1, 32'hEC000000, 1'b1, v_zero, "undef_rst");

    // Reset during a stalled MEMWR drops the request immediately
    fetch(0);
    step(1'b0, 32'hE5821004, 1'b1, v_dst, "str2_decode");
    step(1'b0, 32'hE5821004, 1'b1, v_mas, "str2_memadr");
    step(1'b0, 32'hE5821004, 1'b0, v_mwr, "str2_memwr_wait");
    step(1'b1, 32'hE5821004, 1'b0, v_zero, "str2_rst");
    dp_imm(32'hE2821005, 1'b1, "post_rst_add");

    // Fetch timeout: 16 wait cycles then FAULT
    for (int k = 0; k < 16; k++) step(1'b0, Instr, 1'b0, v_fwt, "timeout_wait");
    step(1'b0, Instr, 1'b0, v_flt, "timeout_fault0");
    step(1'b0, Instr, 1'b1, v_flt, "timeout_fault1");
    step(1'b1, Instr, 1'b1, v_zero, "timeout_rst");
    dp_imm(32'hE2821005, 1'b1, "final_add");

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
